pipe_stage_reg: RTL and testbench

- Generic valid/ready pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload vector and applies backpressure through a handshake instead of a global stall.
- Provides a synchronous flush.
- Has an optional skid entry so that in_ready is driven from a flop and breaks the ready timing path between stages.

---
 rtl/pipe_stage_reg_pkg.sv | 46 ++++
 rtl/pipe_stage_entry.sv | 36 +++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared definitions for the pipeline stage registers.
//   - Per-stage payload widths (IF/ID, ID/EX, EX/MEM, MEM/WB bundles).
//   - NOP payload constants per stage, passed to pipe_stage_reg as RST_VAL.
//   - Stage occupancy state type and its decode from the entry valid bits.
package pipe_stage_reg_pkg;

  localparam int AddrW    = 32;
  localparam int InstW    = 32;
  localparam int DataW    = 32;
  localparam int ALUOpW   = 8;
  localparam int RegAddrW = 5;

  localparam logic [DataW-1:0]  ZeroWord = '0;
  localparam logic [ALUOpW-1:0] ALU_NOP  = '0;

  // pc, inst
  localparam int IFID_W  = AddrW + InstW;
  // pc, aluop, opr1, opr2, wraddr, wreg, resfmem
  localparam int IDEX_W  = AddrW + ALUOpW + 2*DataW + RegAddrW + 2;
  // alures, store data, wraddr, wreg, resfmem
  localparam int EXMEM_W = 2*DataW + RegAddrW + 2;
  // wdata, wraddr, wreg
  localparam int MEMWB_W = DataW + RegAddrW + 1;

  localparam logic [IFID_W-1:0]  IFID_NOP  = {ZeroWord, ZeroWord};
  localparam logic [IDEX_W-1:0]  IDEX_NOP  = {ZeroWord, ALU_NOP, ZeroWord, ZeroWord,
                                              {RegAddrW{1'b0}}, 1'b0, 1'b0};
  localparam logic [EXMEM_W-1:0] EXMEM_NOP = {ZeroWord, ZeroWord, {RegAddrW{1'b0}}, 1'b0, 1'b0};
  localparam logic [MEMWB_W-1:0] MEMWB_NOP = {ZeroWord, {RegAddrW{1'b0}}, 1'b0};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } stage_state_t;

  // The skid entry is only ever occupied while the main entry is, so the
  // two valid bits fully determine the occupancy state.
  function automatic stage_state_t decode_state(input logic m_vld, input logic s_vld);
    if (s_vld)      return ST_SKIDDED;
    else if (m_vld) return ST_FULL;
    else            return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry
//   One valid flag plus payload flop. clear wins over load; both reset and
//   clear return the payload to RST_VAL so a cleared entry reads as a NOP.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     load       capture d and mark valid
//     clear      drop the entry, payload back to RST_VAL
//     d          payload to capture
//     vld, q     entry valid flag and stored payload
module pipe_stage_entry #(
  parameter int             DW      = 8,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d,
  output logic          vld,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= RST_VAL;
    end else if (clear) begin
      vld <= 1'b0;
      q   <= RST_VAL;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic valid/ready pipeline stage register with synchronous flush.
//   SKID=1: main entry M plus skid entry S; in_ready is the inverse of the
//           S valid flop, so the ready path does not chain between stages.
//   SKID=0: single entry; in_ready = !out_valid | out_ready.
//   Optional build macro PIPE_STALL_CNT_EN adds the stall_cnt output, a
//   saturating count of cycles with out_valid & !out_ready (reset only).
//   Ports:
//     clk, rst                      clock, asynchronous active-low reset
//     flush                         synchronous kill of all held entries
//     in_valid, in_ready, in_data   upstream handshake and payload
//     out_valid, out_ready, out_data downstream handshake and payload
//     stall_cnt                     (PIPE_STALL_CNT_EN only) stall cycle count
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int             DW      = IDEX_W,
  parameter logic [DW-1:0]  RST_VAL = '0,
  parameter bit             SKID    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  logic          m_vld;
  logic [DW-1:0] m_q;
  logic          s_vld;
  logic [DW-1:0] s_q;
  logic          in_fire;
  logic          out_fire;
  logic          m_load;
  logic          m_clear;
  logic [DW-1:0] m_d;
  stage_state_t  state;

  assign state     = decode_state(m_vld, s_vld);
  assign out_valid = m_vld;
  assign out_data  = m_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_vld & out_ready;

  // Main entry next-value selection. In SKIDDED in_ready is low, so the
  // only way forward is promoting S into M when M drains.
  always_comb begin
    m_load = 1'b0;
    m_d    = in_data;
    case (state)
      ST_EMPTY:   m_load = in_fire;
      ST_FULL:    m_load = in_fire & out_fire;
      ST_SKIDDED: begin
        m_load = out_fire;
        m_d    = s_q;
      end
      default:    m_load = 1'b0;
    endcase
  end

  // Draining without a refill returns M to the NOP payload; flush overrides
  // everything, while an out_fire in the flush cycle has already completed.
  assign m_clear = flush | (out_fire & ~m_load);

  pipe_stage_entry #(
    .DW      (DW),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .vld   (m_vld),
    .q     (m_q)
  );

  if (SKID) begin : g_skid
    logic s_load;
    logic s_clear;

    // A payload lands in S only when M is held by downstream.
    assign s_load  = (state == ST_FULL) & in_fire & ~out_fire;
    assign s_clear = flush | ((state == ST_SKIDDED) & out_fire);

    pipe_stage_entry #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
    ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (s_load),
      .clear (s_clear),
      .d     (in_data),
      .vld   (s_vld),
      .q     (s_q)
    );

    assign in_ready = ~s_vld;
  end else begin : g_single
    assign s_vld    = 1'b0;
    assign s_q      = RST_VAL;
    assign in_ready = ~m_vld | out_ready;
  end

`ifdef PIPE_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (m_vld & ~out_ready)
      stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives one SKID=1 and one SKID=0 instance (DW=8) with the same inputs.
//   Each instance has its own queue model of held payloads; payloads are
//   pushed when the model accepts them and popped when the model drains.
//   Build with +define+PIPE_STALL_CNT_EN to include the stall counter steps.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready_s, out_valid_s;
  logic [7:0] out_data_s;
  logic       in_ready_n, out_valid_n;
  logic [7:0] out_data_n;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_s, stall_cnt_n;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  q_s[$];
  logic [7:0]  q_n[$];
  logic [7:0]  log_s[$];
  logic [31:0] stall_s = '0;
  logic [31:0] stall_n = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(8), .RST_VAL(8'h00), .SKID(1'b1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt_s)
`endif
  );

  pipe_stage_reg #(.DW(8), .RST_VAL(8'h00), .SKID(1'b0)) dut_n (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_n),
    .in_data   (in_data),
    .out_valid (out_valid_n),
    .out_ready (out_ready),
    .out_data  (out_data_n)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt_n)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Called just after a falling edge: drive inputs, check the presented
  // state against the models, then advance the models across the next rising edge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ory, input logic fl);
    logic       ov_s, ov_n, rdy_s, rdy_n;
    logic [7:0] hd_s, hd_n;
    in_valid  = iv;
    in_data   = id;
    out_ready = ory;
    flush     = fl;
    #1;
    ov_s  = (q_s.size() != 0);
    ov_n  = (q_n.size() != 0);
    rdy_s = (q_s.size() < 2);
    rdy_n = (q_n.size() == 0) | ory;
    hd_s  = 8'h00;
    hd_n  = 8'h00;
    if (ov_s) hd_s = q_s[0];
    if (ov_n) hd_n = q_n[0];
    chk("s_out_valid", out_valid_s, ov_s);
    chk("s_out_data",  out_data_s,  hd_s);
    chk("s_in_ready",  in_ready_s,  rdy_s);
    chk("n_out_valid", out_valid_n, ov_n);
    chk("n_out_data",  out_data_n,  hd_n);
    chk("n_in_ready",  in_ready_n,  rdy_n);
`ifdef PIPE_STALL_CNT_EN
    chk("s_stall_cnt", stall_cnt_s, stall_s);
    chk("n_stall_cnt", stall_cnt_n, stall_n);
`endif
    @(posedge clk);
    if (ov_s & ~ory) stall_s = sat_inc(stall_s);
    if (ov_n & ~ory) stall_n = sat_inc(stall_n);
    if (ov_s & ory) log_s.push_back(q_s.pop_front());
    if (ov_n & ory) void'(q_n.pop_front());
    if (fl) begin
      q_s.delete();
      q_n.delete();
    end else begin
      if (iv & rdy_s) q_s.push_back(id);
      if (iv & rdy_n) q_n.push_back(id);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q_s.delete();
    q_n.delete();
    stall_s = '0;
    stall_n = '0;
  endtask

  initial begin
    logic [7:0] exp_log [3];
    // Reset held with a payload offered
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_s_out_valid", out_valid_s, 1'b0);
    chk("rst_s_out_data",  out_data_s,  8'h00);
    chk("rst_s_in_ready",  in_ready_s,  1'b1);
    chk("rst_n_out_valid", out_valid_n, 1'b0);
    chk("rst_n_in_ready",  in_ready_n,  1'b1);
    rst = 1'b1;
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming 1..4 with downstream always ready
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Skid fill, blocked offer, drain in order
    log_s.delete();
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp_log = '{8'h11, 8'h22, 8'h33};
    chk("skid_log_len", log_s.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("skid_log_item", (i < log_s.size()) ? {24'h0, log_s[i]} : 32'hDEAD, exp_log[i]);

    // Flush while SKIDDED with a payload offered
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_s_in_ready",  in_ready_s,  1'b1);
    chk("flush_s_out_valid", out_valid_s, 1'b0);
    chk("flush_s_out_data",  out_data_s,  8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // SKID=0 combinational ready follows out_ready within the cycle
    step(1'b1, 8'h99, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hAB; out_ready = 1'b0;
    #1;
    chk("n_ready_blocked", in_ready_n, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("n_ready_comb", in_ready_n, 1'b1);
    step(1'b1, 8'hAB, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-transfer
    step(1'b1, 8'h05, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_s_out_valid", out_valid_s, 1'b0);
    chk("arst_s_out_data",  out_data_s,  8'h00);
    chk("arst_s_in_ready",  in_ready_s,  1'b1);
    chk("arst_n_out_valid", out_valid_n, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

`ifdef PIPE_STALL_CNT_EN
    // Stall for five cycles (the last one is the flush cycle)
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("stall_s_after_flush", stall_cnt_s, 32'd5);
    chk("stall_n_after_flush", stall_cnt_n, 32'd5);
    rst = 1'b0;
    #1;
    chk("stall_s_reset", stall_cnt_s, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
`endif

    // Mixed traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
